decrypted_write_buffer: RTL and testbench
=========================================

// Module: decrypted_write_buffer
// PURPOSE
//  Write-posting FIFO between the address decoder and the decrypted-image memory.
//  - Captures decrypted-region stores (decrypted_we, word index, data) from the processor memory stage.
//  - Drains them into the memory write port whenever the host/readout side is not using it.
//  - Stalls the processor only when the queue is full or a flush is in progress.
// PARAMETERS
//  N      32  data width and width of incoming word index
//  AW     15  memory word-address width (covers indices 0..0x7EFE of region 0x404..0x1FFFF)
//  DEPTH  4   FIFO entries; power of two, >=2
// PORTS
//  clk             in   1            system clock, rising edge
//  rst             in   1            synchronous, active-high reset
//  decrypted_we    in   1            store request from address decoder
//  decrypted_addr  in   N            word index from decoder ((address-'h404)/4)
//  data_input      in   N            store data
//  host_req        in   1            readout side owns memory port this cycle (priority)
//  flush           in   1            1-cycle pulse: drain all entries, then report
//  stall           out  1            processor must hold current store
//  mem_we          out  1            write strobe to decrypted memory
//  mem_addr        out  AW           write word address
//  mem_data        out  N            write data
//  count           out  $clog2(DEPTH)+1  entries held
//  flush_done      out  1            1-cycle pulse when flush completes
//  range_err       out  1            sticky: a store with index >= 2**AW was dropped
// BEHAVIOUR
//  Reset: FIFO empty, count=0, pointers=0, mem_we=0, stall=0, flush_done=0, range_err=0, state=RUN.
//  Reset mid-operation discards all queued entries; nothing is written after the reset edge.
//  Push:
//  - On the clk edge where decrypted_we=1, stall=0 and decrypted_addr < 2**AW, write entry {addr[AW-1:0], data} at wr_ptr.
//  - Then advance wr_ptr (mod DEPTH).
//  Out-of-range push: decrypted_we=1, stall=0 and addr >= 2**AW -> entry dropped; range_err set until rst.
//  Pop:
//  - pop = (count!=0) && !host_req.
//  - mem_we=pop, combinational from the registered FIFO head; mem_addr/mem_data = head entry.
//  - rd_ptr advances on that edge.
//  - mem_addr/mem_data hold the head value even while mem_we=0.
//  Latency: store accepted at edge t -> earliest mem_we in cycle after t (1 cycle). Order is strictly FIFO.
//  Simultaneous push+pop: both happen; count unchanged. Allowed at full (count=DEPTH) only if stall=0.
//  stall (combinational):
//  - state==FLUSH, or
//  - (count==DEPTH && decrypted_we && !pop), or
//  - (state==RUN && flush).
//  - Processor holds decrypted_we/addr/data stable while stall=1; a stalled store is not pushed.
//  host_req held high: no pops; queue fills; further stores stall; no entry lost or duplicated.
//  FSM:
//  - RUN: flush=1 -> FLUSH (no push that cycle).
//  - FLUSH: pops as above, no pushes.
//    - count==0 -> DONE.
//    - Includes flush issued with empty queue: FLUSH lasts exactly 1 cycle.
//  - DONE: flush_done=1 for one cycle, stall=0 -> RUN.
//  - flush asserted in FLUSH/DONE is ignored.
//  count: incr on push-only, decr on pop-only; never exceeds DEPTH nor wraps below 0.
//  Pointers: $clog2(DEPTH) bits, natural wrap-around.
// TESTING
//  1. Reset, single store idx 5 data 'hA5A5_0001, host_req=0 -> mem_we=1 next cycle, mem_addr=5, mem_data='hA5A5_0001; count back to 0.
//  2. host_req=1, stores idx 1..5 back-to-back -> count=4 after 4th; stall=1 on 5th; release host_req.
//     Required: mem writes idx 1,2,3,4,5 in order on consecutive cycles, 5th pushed once.
//  3. count=4, host_req=0, new store same cycle as pop -> no stall; count stays 4; data order preserved.
//  4. Store idx 'h8000 (>=2**15) -> no mem_we, count unchanged, range_err=1 and stays 1 until rst.
//  5. Queue 3 entries with host_req=1, pulse flush, drop host_req after 2 cycles.
//     Required: stall=1 throughout FLUSH; 3 writes; flush_done pulses one cycle after count hits 0; stall=0 same cycle.
//  6. Queue 2 entries, assert rst for 1 cycle -> count=0, mem_we=0 next cycle; subsequent store idx 9 written normally.

Source files
------------

// File: rtl/decrypted_write_buffer.sv
// Write-posting FIFO for decrypted-region stores; head drives the memory port combinationally (1-cycle store-to-write).
// Backpressure: stall when full with no pop this cycle, when a flush is requested, or while draining for a flush.
module decrypted_write_buffer #(
  parameter int N     = 32,
  parameter int AW    = 15,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     decrypted_we,
  input  logic [N-1:0]             decrypted_addr,
  input  logic [N-1:0]             data_input,
  input  logic                     host_req,
  input  logic                     flush,
  output logic                     stall,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [N-1:0]             mem_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     flush_done,
  output logic                     range_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_mem [DEPTH];
  logic [N-1:0]    data_mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            pop, push, accept, in_range, full;

  assign full     = (count == CW'(DEPTH));
  assign pop      = (count != '0) && !host_req;
  assign in_range = ((decrypted_addr >> AW) == '0);
  assign accept   = decrypted_we && !stall;
  assign push     = accept && in_range;

  assign mem_we   = pop;
  assign mem_addr = addr_mem[rd_ptr];
  assign mem_data = data_mem[rd_ptr];

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    stall      = (state_q == FLUSH) || (full && decrypted_we && !pop) ||
                 (state_q == RUN && flush);
    case (state_q)
      RUN:     if (flush) state_d = FLUSH;
      // count is the registered value, so an empty-queue flush spends one cycle here
      FLUSH:   if (count == '0) state_d = DONE;
      DONE: begin
        flush_done = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      range_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (accept && !in_range) range_err <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= decrypted_addr[AW-1:0];
      data_mem[wr_ptr] <= data_input;
    end
  end

endmodule

// File: tb/tb_decrypted_write_buffer.sv
// Randomized and directed bench for decrypted_write_buffer against a queue-based reference model.
module tb_decrypted_write_buffer;

  localparam int N = 32, AW = 15, DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, decrypted_we, host_req, flush;
  logic [N-1:0]  decrypted_addr, data_input;
  logic          stall, mem_we, flush_done, range_err;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_data;
  logic [2:0]    count;

  int checks = 0;
  int failures = 0;

  logic [46:0] mq[$];
  logic        m_flushing = 1'b0, m_done = 1'b0, m_rerr = 1'b0, m_stall = 1'b0;

  decrypted_write_buffer #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .decrypted_we(decrypted_we), .decrypted_addr(decrypted_addr),
    .data_input(data_input), .host_req(host_req), .flush(flush), .stall(stall),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .count(count),
    .flush_done(flush_done), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, check outputs mid-cycle against the model, advance the model at the edge.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic h, input logic f, input logic r);
    int n;
    logic p, acc;
    decrypted_we = we; decrypted_addr = a; data_input = d;
    host_req = h; flush = f; rst = r;
    @(negedge clk);
    n = mq.size();
    p = (n != 0) && !h;
    m_stall = m_flushing || (n == DEPTH && we && !p) || (!m_flushing && !m_done && f);
    chk("stall", stall, m_stall);
    chk("mem_we", mem_we, p);
    if (n != 0) begin
      chk("mem_addr", mem_addr, mq[0][46:32]);
      chk("mem_data", mem_data, mq[0][31:0]);
    end
    chk("count", count, n);
    chk("flush_done", flush_done, m_done);
    chk("range_err", range_err, m_rerr);
    if (r) begin
      mq.delete();
      m_flushing = 1'b0; m_done = 1'b0; m_rerr = 1'b0; m_stall = 1'b0;
    end else begin
      acc = we && !m_stall;
      if (p) void'(mq.pop_front());
      if (acc) begin
        if (a < 32'h8000) mq.push_back({a[14:0], d});
        else m_rerr = 1'b1;
      end
      if (m_done) m_done = 1'b0;
      else if (m_flushing) begin
        if (n == 0) begin m_flushing = 1'b0; m_done = 1'b1; end
      end else if (f) m_flushing = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic h);
    int tries = 0;
    do begin
      step(1'b1, a, d, h, 1'b0, 1'b0);
      tries++;
    end while (m_stall && tries < 50);
    if (m_stall) chk("store_timeout", 1, 0);
  endtask

  task automatic idle(input int cycles, input logic h);
    for (int i = 0; i < cycles; i++) step(1'b0, 32'h0, 32'h0, h, 1'b0, 1'b0);
  endtask

  initial begin
    logic        cur_we, cur_h, cur_f, cur_r;
    logic [31:0] cur_a, cur_d;

    rst = 1'b1; decrypted_we = 1'b0; decrypted_addr = '0; data_input = '0;
    host_req = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_stall", stall, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_range_err", range_err, 0);
    rst = 1'b0;

    // single store reaches memory the next cycle
    step(1'b1, 32'd5, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
    chk("t1_we", mem_we, 1);
    chk("t1_addr", mem_addr, 5);
    chk("t1_data", mem_data, 32'hA5A5_0001);
    idle(1, 1'b0);
    chk("t1_count", count, 0);

    // host owns the port: fill, then the fifth store stalls
    for (int i = 1; i <= 4; i++) store(i, 32'hB000_0000 + i, 1'b1);
    chk("t2_count", count, 4);
    step(1'b1, 32'd5, 32'hB000_0005, 1'b1, 1'b0, 1'b0);
    chk("t2_stall", stall, 1);
    store(32'd5, 32'hB000_0005, 1'b0);
    idle(6, 1'b0);

    // full queue, push alongside pop
    for (int i = 0; i < 4; i++) store(32'h10 + i, 32'hC000_0000 + i, 1'b1);
    step(1'b1, 32'h20, 32'hC000_0020, 1'b0, 1'b0, 1'b0);
    chk("t3_count", count, 4);
    idle(6, 1'b0);

    // out-of-range store is dropped, error sticks
    step(1'b1, 32'h8000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    chk("t4_range_err", range_err, 1);
    chk("t4_count", count, 0);
    idle(3, 1'b0);
    chk("t4_range_sticky", range_err, 1);

    // flush with three queued entries, host releases after two cycles
    for (int i = 0; i < 3; i++) store(32'h30 + i, 32'hD000_0000 + i, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    idle(6, 1'b0);

    // flush with an empty queue
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0);

    // reset discards queued entries
    for (int i = 0; i < 2; i++) store(32'h40 + i, 32'hE000_0000 + i, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("t6_count", count, 0);
    chk("t6_mem_we", mem_we, 0);
    chk("t6_range_err", range_err, 0);
    store(32'd9, 32'h0000_0009, 1'b0);
    idle(2, 1'b0);

    // random traffic; the processor holds a stalled store
    cur_we = 1'b0; cur_a = '0; cur_d = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!(m_stall && cur_we)) begin
        cur_we = ($urandom_range(0, 9) < 6);
        cur_a  = ($urandom_range(0, 29) == 0) ? (32'h8000 + $urandom_range(0, 255))
                                               : 32'($urandom_range(0, 32'h7FFF));
        cur_d  = $urandom;
      end
      cur_h = ($urandom_range(0, 9) < 3);
      cur_f = ($urandom_range(0, 39) == 0);
      cur_r = ($urandom_range(0, 199) == 0);
      step(cur_we, cur_a, cur_d, cur_h, cur_f, cur_r);
      if (cur_r) m_stall = 1'b0;
    end
    idle(8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
